// File: rtl/inv_key_expansion_pkg.sv
// Shared widths, AES-128 constants and FSM encoding for the reverse key schedule.
package inv_key_expansion_pkg;

  localparam int unsigned StateWidth      = 128;
  localparam int unsigned WordWidth       = 32;
  localparam int unsigned RoundWidth      = 4;
  localparam int unsigned Aes128LastRound = 10;

  // Entry 0 is never used; the reverse step only runs for rounds 1..10.
  localparam logic [7:0] RconTable [11] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [0:0] {
    StIdle,
    StOut
  } state_e;

  function automatic logic [7:0] rcon(input logic [RoundWidth-1:0] round);
    if (round > 4'd10) begin
      return 8'h00;
    end
    return RconTable[round];
  endfunction

endpackage

// File: rtl/inv_key_expansion_if.sv
// Key-load / round-key stream bundle between the loader, this block and the inverse rounds.
interface inv_key_expansion_if;
  import inv_key_expansion_pkg::*;

  logic                  start;
  logic [StateWidth-1:0] keyInput;
  logic [RoundWidth-1:0] startRound;
  logic [StateWidth-1:0] keyOutput;
  logic [RoundWidth-1:0] keyRound;
  logic                  keyValid;
  logic                  keyReady;
  logic                  busy;
  logic                  done;

  modport master (
    output start, keyInput, startRound, keyReady,
    input  keyOutput, keyRound, keyValid, busy, done
  );

  modport slave (
    input  start, keyInput, startRound, keyReady,
    output keyOutput, keyRound, keyValid, busy, done
  );

endinterface

// File: rtl/inv_key_expansion_sub_byte.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word.
module inv_key_expansion_sub_byte (
  input  logic [31:0] data,
  output logic [31:0] result
);

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign result[8*i +: 8] = Sbox[data[8*i +: 8]];
  end

endmodule

// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: loads round key N and streams keys N..0 over valid/ready.
module inv_key_expansion
  import inv_key_expansion_pkg::*;
#(
  parameter int unsigned LAST_ROUND = Aes128LastRound
) (
  input  logic                clk,
  input  logic                reset,
  inv_key_expansion_if.slave  bus
);

  state_e                state_q, state_d;
  logic [StateWidth-1:0] key_q, key_d;
  logic [RoundWidth-1:0] round_q, round_d;
  logic                  done_q, done_d;

  logic [WordWidth-1:0]  w0, w1, w2, w3;
  logic [WordWidth-1:0]  p0, p1, p2, p3;
  logic [WordWidth-1:0]  rot_p3, sub_p3;
  logic [StateWidth-1:0] prev_key;
  logic                  start_ok;
  logic                  accept;

  // Undo one forward step: the last three words fall out of adjacent XORs, and the
  // rebuilt W3 of the previous round drives the S-box term for word 0.
  assign {w0, w1, w2, w3} = key_q;
  assign p3     = w3 ^ w2;
  assign p2     = w2 ^ w1;
  assign p1     = w1 ^ w0;
  assign rot_p3 = {p3[23:0], p3[31:24]};

  inv_key_expansion_sub_byte u_sub_byte (
    .data   (rot_p3),
    .result (sub_p3)
  );

  assign p0       = w0 ^ sub_p3 ^ {rcon(round_q), 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

  assign start_ok = (32'(bus.startRound) <= LAST_ROUND);
  assign accept   = (state_q == StOut) && bus.keyReady;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    key_d   = key_q;
    round_d = round_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && start_ok) begin
          key_d   = bus.keyInput;
          round_d = bus.startRound;
          state_d = StOut;
        end
      end
      StOut: begin
        if (accept) begin
          if (round_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key;
            round_d = round_q - RoundWidth'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q   <= '0;
      round_q <= '0;
    end else begin
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign bus.keyOutput = key_q;
  assign bus.keyRound  = round_q;
  assign bus.keyValid  = (state_q == StOut);
  assign bus.busy      = (state_q == StOut);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: random keys expanded forward by a GF(2^8)-based model.
module tb_inv_key_expansion;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  inv_key_expansion_if bus ();

  inv_key_expansion #(
    .LAST_ROUND (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_keys [0:10];
  logic [127:0] seen     [0:10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] av;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      av = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_ref[a] = av;
    end
  endtask

  // Forward AES-128 expansion of the cipher key into exp_keys[0..10].
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]}
            ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Drives one start and follows the stream down to round 0; returns in the done cycle.
  task automatic run_walk(input logic [127:0] key, input logic [3:0] sr, input bit rand_ready,
                          input int stall_round, input int stall_cycles, input bit poke_start);
    int   waits;
    bit   acc;
    logic rdy;
    bus.keyInput   = key;
    bus.startRound = sr;
    bus.start      = 1'b1;
    bus.keyReady   = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.keyInput = {$urandom, $urandom, $urandom, $urandom};
    total++;
    if (bus.done !== 1'b0) $display("FAIL walk_done_early got %b want 0", bus.done);
    else passed++;
    for (int r = int'(sr); r >= 0; r--) begin
      waits = 0;
      acc   = 1'b0;
      while (!acc) begin
        if (r == stall_round && waits < stall_cycles) rdy = 1'b0;
        else if (rand_ready) rdy = ($urandom_range(0, 3) != 0);
        else rdy = 1'b1;
        bus.keyReady = rdy;
        total++;
        if (bus.keyValid !== 1'b1) $display("FAIL walk_valid r=%0d got %b want 1", r, bus.keyValid);
        else passed++;
        total++;
        if (bus.busy !== 1'b1) $display("FAIL walk_busy r=%0d got %b want 1", r, bus.busy);
        else passed++;
        total++;
        if (bus.keyRound !== 4'(r))
          $display("FAIL walk_round got %0d want %0d", bus.keyRound, r);
        else passed++;
        total++;
        if (bus.keyOutput !== exp_keys[r])
          $display("FAIL walk_key r=%0d got %h want %h", r, bus.keyOutput, exp_keys[r]);
        else passed++;
        seen[r] = bus.keyOutput;
        if (poke_start && (r == 5 || r == 3) && waits == 0) begin
          bus.start      = 1'b1;
          bus.startRound = 4'd2;
          bus.keyInput   = {$urandom, $urandom, $urandom, $urandom};
        end
        step();
        bus.start = 1'b0;
        acc   = rdy;
        waits++;
        if (waits > 60) begin
          total++;
          $display("FAIL walk_budget r=%0d got %0d cycles want <=60", r, waits);
          acc = 1'b1;
        end
      end
    end
    total++;
    if (bus.done !== 1'b1) $display("FAIL walk_done got %b want 1", bus.done);
    else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL walk_busy_end got %b want 0", bus.busy);
    else passed++;
    total++;
    if (bus.keyValid !== 1'b0) $display("FAIL walk_valid_end got %b want 0", bus.keyValid);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    total++;
    if (bus.keyValid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.keyValid); else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
    total++;
    if (bus.keyOutput !== 128'h0) $display("FAIL reset_key got %h want 0", bus.keyOutput); else passed++;
    total++;
    if (bus.keyRound !== 4'h0) $display("FAIL reset_round got %0d want 0", bus.keyRound); else passed++;
    reset = 1'b1;
    step();
    total++;
    if (bus.keyValid !== 1'b0) $display("FAIL reset_idle got %b want 0", bus.keyValid); else passed++;
  endtask

  task automatic test_fips();
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_walk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 1'b0, -1, 0, 1'b0);
    total++;
    if (seen[9] !== 128'hac7766f319fadc2128d12941575c006e)
      $display("FAIL fips_r9 got %h want ac7766f319fadc2128d12941575c006e", seen[9]);
    else passed++;
    total++;
    if (seen[1] !== 128'ha0fafe1788542cb123a339392a6c7605)
      $display("FAIL fips_r1 got %h want a0fafe1788542cb123a339392a6c7605", seen[1]);
    else passed++;
    total++;
    if (seen[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c)
      $display("FAIL fips_r0 got %h want 2b7e151628aed2a6abf7158809cf4f3c", seen[0]);
    else passed++;
    step();
    total++;
    if (bus.done !== 1'b0) $display("FAIL fips_done_pulse got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_backpressure();
    expand({$urandom, $urandom, $urandom, $urandom});
    run_walk(exp_keys[10], 4'd10, 1'b0, 7, 3, 1'b0);
    step();
  endtask

  task automatic test_start_filter();
    bus.start      = 1'b1;
    bus.startRound = 4'd12;
    bus.keyInput   = {$urandom, $urandom, $urandom, $urandom};
    step();
    bus.start = 1'b0;
    total++;
    if (bus.keyValid !== 1'b0) $display("FAIL filter_valid got %b want 0", bus.keyValid); else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL filter_busy got %b want 0", bus.busy); else passed++;
    step();
    total++;
    if (bus.keyValid !== 1'b0) $display("FAIL filter_valid2 got %b want 0", bus.keyValid); else passed++;
    total++;
    if (bus.done !== 1'b0) $display("FAIL filter_done got %b want 0", bus.done); else passed++;
    expand({$urandom, $urandom, $urandom, $urandom});
    run_walk(exp_keys[10], 4'd10, 1'b0, -1, 0, 1'b1);
    step();
  endtask

  task automatic test_round_zero();
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    exp_keys[0] = k;
    run_walk(k, 4'd0, 1'b0, -1, 0, 1'b0);
    step();
    total++;
    if (bus.keyValid !== 1'b0) $display("FAIL zero_idle got %b want 0", bus.keyValid); else passed++;
    total++;
    if (bus.done !== 1'b0) $display("FAIL zero_done_pulse got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_back_to_back();
    expand({$urandom, $urandom, $urandom, $urandom});
    run_walk(exp_keys[10], 4'd10, 1'b0, -1, 0, 1'b0);
    // Start raised in the done cycle must not be lost.
    expand({$urandom, $urandom, $urandom, $urandom});
    run_walk(exp_keys[4], 4'd4, 1'b0, -1, 0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid_walk();
    int n;
    expand({$urandom, $urandom, $urandom, $urandom});
    bus.keyInput   = exp_keys[10];
    bus.startRound = 4'd10;
    bus.start      = 1'b1;
    bus.keyReady   = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    while (bus.keyRound !== 4'd5 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (bus.keyRound !== 4'd5) $display("FAIL midreset_reach got %0d want 5", bus.keyRound); else passed++;
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++;
    if (bus.keyValid !== 1'b0) $display("FAIL midreset_valid got %b want 0", bus.keyValid); else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", bus.busy); else passed++;
    total++;
    if (bus.done !== 1'b0) $display("FAIL midreset_done got %b want 0", bus.done); else passed++;
    total++;
    if (bus.keyOutput !== 128'h0) $display("FAIL midreset_key got %h want 0", bus.keyOutput); else passed++;
    total++;
    if (bus.keyRound !== 4'h0) $display("FAIL midreset_round got %0d want 0", bus.keyRound); else passed++;
    step();
    total++;
    if (bus.keyValid !== 1'b0) $display("FAIL midreset_idle got %b want 0", bus.keyValid); else passed++;
    expand({$urandom, $urandom, $urandom, $urandom});
    run_walk(exp_keys[10], 4'd10, 1'b0, -1, 0, 1'b0);
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 100; i++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      run_walk(exp_keys[10], 4'd10, 1'b1, -1, 0, 1'b0);
      step();
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.keyInput   = '0;
    bus.startRound = '0;
    bus.keyReady   = 1'b0;
    build_sbox();
    test_reset();
    test_fips();
    test_backpressure();
    test_start_filter();
    test_round_zero();
    test_back_to_back();
    test_reset_mid_walk();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inv_key_expansion.md
# inv_key_expansion

- Reverse AES-128 key schedule for the decryption datapath.
- Loads one round key, typically the round-10 key produced by the forward expansion, and walks the schedule backwards.
- Emits round keys N, N-1, …, 0 in order, one per valid/ready handshake, so the inverse-cipher rounds get their keys on the fly without storing all eleven.
- Sits between the key-load logic and the inverse round datapath.

## Interface

Parameters:
- LAST_ROUND, 10, highest legal round index for AES-128; start requests with a higher round are rejected.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- start  in  1  one-cycle request to begin a walk; honoured only while busy=0.
- keyInput  in  128  round key for round startRound; word 0 is bits [127:96].
- startRound  in  4  round index of keyInput, 0..LAST_ROUND.
- keyOutput  out  128  current round key; held stable while keyValid=1.
- keyRound  out  4  round index of keyOutput.
- keyValid  out  1  keyOutput/keyRound are valid.
- keyReady  in  1  consumer accepts the key when keyValid & keyReady at posedge.
- busy  out  1  walk in progress; high from the start acceptance until after round 0 is accepted.
- done  out  1  one-cycle pulse on the cycle after round 0 is accepted.

## Operation

FSM states: IDLE, OUT.

- **IDLE**
  - keyValid=0, busy=0.
  - Start is accepted when start=1 and startRound≤LAST_ROUND. On acceptance: key register←keyInput, round←startRound, go to OUT.
  - start with startRound>LAST_ROUND is ignored: no state change, done stays 0.
- **OUT**
  - keyValid=1, busy=1.
  - keyOutput is the key register and keyRound is the round register.
  - Acceptance with round≠0: key register←prev(key, round), round←round−1, stay in OUT.
  - Acceptance with round=0: go to IDLE, done=1 for one cycle.
  - No acceptance: all outputs hold.
  - start is ignored while in OUT.

prev(W, r) function, with W = {W0,W1,W2,W3} and W0 = [127:96]:
- P3 = W3^W2, P2 = W2^W1, P1 = W1^W0.
- P0 = W0 ^ SubWord(RotWord(P3)) ^ {Rcon(r), 24'h0}.
- RotWord(x) = {x[23:0], x[31:24]}.
- Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36.

Datapath:
- All XORs are 32-bit bitwise; no carries.
- prev() is combinational from the key register; one round per cycle, no pipeline stall beyond the handshake.

Reset (reset=0 at posedge) from any state, including mid-walk:
- State→IDLE.
- keyOutput=0, keyRound=0, keyValid=0, busy=0, done=0.
- Any in-flight walk is abandoned.

## Timing

- start accepted at edge T → keyValid=1 with keyRound=startRound from T+1 (1-cycle latency).
- Handshake accepted at edge A → the next key is visible from A+1.
- With keyReady held high, keys stream one per cycle; a full walk from round 10 shows keyValid high for 11 consecutive cycles.
- Round 0 accepted at edge A:
  - keyValid and busy low from A+1.
  - done high during cycle A+1 only.
- start asserted during cycle A+1 (IDLE) is accepted at edge A+2; no back-to-back start in the done cycle is lost.
- startRound=0: a single key is emitted unchanged, then done.
- keyReady low indefinitely: keyOutput and keyRound hold; no timeout.

## Structure

- Shared package entries:
  - AES state/word widths (128/32).
  - Rcon constant table.
  - The AES-128 value LAST_ROUND=10.
  - FSM state encoding (IDLE/OUT).
- Reuse the existing subByte sub-module (4× S-box) for SubWord on the rotated P3.
- Rcon indexed by the current round comes from the existing rcon module or the package table; no second S-box instance.
- One FSM always block plus one key/round register block; all state is synchronously reset.

## Test plan

- **FIPS-197 A.1 full walk**
  - Stimulus: start, startRound=10, keyInput=d014f9a8c9ee2589e13f0cc8b6630ca6, keyReady=1.
  - Required: keyRound 10..0 on consecutive cycles, round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses once, busy drops with it.
- **Backpressure**
  - Stimulus: keyReady low for 3 cycles at round 7, then high.
  - Required: keyOutput/keyRound stay at round 7 through the stall, then the sequence resumes with no skipped or repeated round.
- **Start filtering**
  - Stimulus: start with startRound=12; start pulses during OUT.
  - Required: no keyValid for the first; the second has no effect on the ongoing sequence.
- **startRound=0**
  - Stimulus: start with startRound=0, keyInput=K.
  - Required: one key K with keyRound=0, then done, then IDLE.
- **Reset mid-walk**
  - Stimulus: reset=0 during round 5 for one cycle.
  - Required: next cycle keyValid=0, busy=0, done=0, keyOutput=0, keyRound=0; a following start runs a clean walk.
- **Random cross-check**
  - Stimulus: 100 random 128-bit keys expanded forward by a reference model, with round 10 fed in.
  - Required: every emitted round key matches the forward schedule.
